// File: rtl/read_register_pkg.sv
// Shared constants and write-enable helpers for the
// read side of the register file.
package read_register_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREG      = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_t;

  function automatic logic [ADDR_W:0] wen_count(
    input logic [NREG-1:0] w
  );
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++)
      n = n + {{ADDR_W{1'b0}}, w[i]};
    return n;
  endfunction

  function automatic logic wen_onehot(
    input logic [NREG-1:0] w
  );
    return wen_count(w) == 1;
  endfunction

  function automatic logic wen_multi(
    input logic [NREG-1:0] w
  );
    return wen_count(w) > 1;
  endfunction

  // Only meaningful when w is one-hot; OR-reduces bit indices.
  function automatic logic [ADDR_W-1:0] wen_index(
    input logic [NREG-1:0] w
  );
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREG; i++)
      if (w[i]) idx = idx | ADDR_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/read_register_read_port.sv
// One registered read port: EMPTY/FULL handshake control,
// output data register and same-cycle write forwarding.
module read_port
  import read_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              valid,
  output logic [WIDTH-1:0]  data,
  input  logic              out_ready,
  input  logic [WIDTH-1:0]  rdata,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [WIDTH-1:0]  wdata
);

  port_state_t      state;
  logic             hit;
  logic [WIDTH-1:0] load;

  assign valid = (state == FULL);
  assign ready = !valid || out_ready;
  assign hit   = wr_ok && (wr_idx == addr);
  assign load  = hit ? wdata : rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (req) begin
            state <= FULL;
            data  <= load;
          end
        end
        FULL: begin
          // Stalled when !out_ready: data is a snapshot.
          if (out_ready) begin
            if (req) data  <= load;
            else     state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/read_register.sv
// Eight-entry register file with one-hot write and two
// independent registered read ports with forwarding.
module read_register
  import read_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREG-1:0]   wen,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ready,
  output logic              a_valid,
  output logic [WIDTH-1:0]  a_data,
  input  logic              a_out_ready,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ready,
  output logic              b_valid,
  output logic [WIDTH-1:0]  b_data,
  input  logic              b_out_ready,
  output logic              wen_err
);

  logic [WIDTH-1:0]  regs [NREG];
  logic              wr_ok;
  logic              wr_bad;
  logic [ADDR_W-1:0] wr_idx;
  logic [WIDTH-1:0]  a_rdata;
  logic [WIDTH-1:0]  b_rdata;

  assign wr_ok   = wen_onehot(wen);
  assign wr_bad  = wen_multi(wen);
  assign wr_idx  = wen_index(wen);
  assign a_rdata = regs[a_addr];
  assign b_rdata = regs[b_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      wen_err <= 1'b0;
    end else begin
      if (wr_ok)
        regs[wr_idx] <= wdata;
      if (wr_bad)
        wen_err <= 1'b1;
    end
  end

  read_port #(.WIDTH(WIDTH)) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (a_req),
    .addr      (a_addr),
    .ready     (a_ready),
    .valid     (a_valid),
    .data      (a_data),
    .out_ready (a_out_ready),
    .rdata     (a_rdata),
    .wr_ok     (wr_ok),
    .wr_idx    (wr_idx),
    .wdata     (wdata)
  );

  read_port #(.WIDTH(WIDTH)) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (b_req),
    .addr      (b_addr),
    .ready     (b_ready),
    .valid     (b_valid),
    .data      (b_data),
    .out_ready (b_out_ready),
    .rdata     (b_rdata),
    .wr_ok     (wr_ok),
    .wr_idx    (wr_idx),
    .wdata     (wdata)
  );

endmodule
